// File: rtl/seq_pattern_pkg.sv
// Shared constants for the serial pattern transmitter and its detector-side users.
package seq_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_GAP   = 3'b100
  } state_e;

  localparam logic       IDLE_LEVEL_DFLT = 1'b1;
  localparam logic [7:0] PAT_0101        = 8'b0101_0101;

endpackage

// File: rtl/seq_pattern_tx_shifter.sv
// Load/shift register for one frame: presents the next serial bit and flags the last bit.
module tx_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] load_val_i,
  output logic         next_bit_o,
  output logic         last_bit_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  // Only the bits still to be sent are kept; the MSB leaves on the load edge.
  logic [W-2:0] sr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= load_val_i[W-2:0];
      cnt_q <= CW'(W - 1);
    end else if (shift_i) begin
      sr_q  <= sr_q << 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign next_bit_o = load_i ? load_val_i[W-1] : sr_q[W-2];
  assign last_bit_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, rpt+1 times, with optional idle gaps.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int   W          = 8,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DFLT,
  parameter int   RPT_W      = 8,
  parameter int   GAP_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [W-1:0]     pattern_i,
  input  logic [RPT_W-1:0] rpt_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             dout_o,
  output logic             dout_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [RPT_W-1:0] frame_idx_o
);

  state_e state_q, state_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [RPT_W-1:0] frames_left_q, frames_left_d;
  logic [RPT_W-1:0] frame_idx_q, frame_idx_d;
  logic [GAP_W-1:0] gap_q, gap_d, gapcnt_q, gapcnt_d;
  logic dout_q, dout_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic load, shift, sh_bit, last_bit;
  logic [W-1:0] load_val;

  tx_shifter #(.W(W)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .shift_i    (shift),
    .load_val_i (load_val),
    .next_bit_o (sh_bit),
    .last_bit_o (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pat_q         <= '0;
      frames_left_q <= '0;
      frame_idx_q   <= '0;
      gap_q         <= '0;
      gapcnt_q      <= '0;
      dout_q        <= IDLE_LEVEL;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      frames_left_q <= frames_left_d;
      frame_idx_q   <= frame_idx_d;
      gap_q         <= gap_d;
      gapcnt_q      <= gapcnt_d;
      dout_q        <= dout_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = start_i ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: begin
        if (abort_i)                    state_d = ST_IDLE;
        else if (!last_bit)             state_d = ST_SHIFT;
        else if (frames_left_q == '0)   state_d = ST_IDLE;
        else if (gap_q == '0)           state_d = ST_SHIFT;
        else                            state_d = ST_GAP;
      end
      ST_GAP: begin
        if (abort_i)                    state_d = ST_IDLE;
        else if (gapcnt_q == '0)        state_d = ST_SHIFT;
        else                            state_d = ST_GAP;
      end
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values; anything not driven falls back to idle.
  always_comb begin
    dout_d        = IDLE_LEVEL;
    valid_d       = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    pat_d         = pat_q;
    frames_left_d = frames_left_q;
    frame_idx_d   = frame_idx_q;
    gap_d         = gap_q;
    gapcnt_d      = gapcnt_q;
    load          = 1'b0;
    shift         = 1'b0;
    load_val      = pat_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pat_d         = pattern_i;
          frames_left_d = rpt_i;
          gap_d         = gap_i;
          frame_idx_d   = '0;
          load_val      = pattern_i;
          load          = 1'b1;
          dout_d        = sh_bit;
          valid_d       = 1'b1;
          busy_d        = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort_i) begin
          frame_idx_d = '0;
        end else if (!last_bit) begin
          shift   = 1'b1;
          dout_d  = sh_bit;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else if (frames_left_q == '0) begin
          done_d      = 1'b1;
          frame_idx_d = '0;
        end else if (gap_q == '0) begin
          load          = 1'b1;
          dout_d        = sh_bit;
          valid_d       = 1'b1;
          busy_d        = 1'b1;
          frames_left_d = frames_left_q - RPT_W'(1);
          frame_idx_d   = frame_idx_q + RPT_W'(1);
        end else begin
          busy_d   = 1'b1;
          gapcnt_d = gap_q - GAP_W'(1);
        end
      end
      ST_GAP: begin
        if (abort_i) begin
          frame_idx_d = '0;
        end else if (gapcnt_q == '0) begin
          load          = 1'b1;
          dout_d        = sh_bit;
          valid_d       = 1'b1;
          busy_d        = 1'b1;
          frames_left_d = frames_left_q - RPT_W'(1);
          frame_idx_d   = frame_idx_q + RPT_W'(1);
        end else begin
          busy_d   = 1'b1;
          gapcnt_d = gapcnt_q - GAP_W'(1);
        end
      end
      default: begin
        frame_idx_d = '0;
      end
    endcase
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign frame_idx_o  = frame_idx_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: per-cycle scoreboard fed by a frame model, table vectors plus corner sequences.
module tb_seq_pattern_tx;
  import seq_pattern_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, abort_i;
  logic [7:0] pattern_i, rpt_i;
  logic [3:0] gap_i;
  logic       dout_o, dout_valid_o, busy_o, done_o;
  logic [7:0] frame_idx_o;

  seq_pattern_tx dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .pattern_i    (pattern_i),
    .rpt_i        (rpt_i),
    .gap_i        (gap_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .frame_idx_o  (frame_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       dout;
    logic       valid;
    logic       busy;
    logic       done;
    logic [7:0] fidx;
  } obs_t;

  typedef struct {
    logic [7:0] pat;
    int         rpt;
    int         gap;
    bit         abort_too;
    int         exp_valid;
    int         exp_busy;
  } vec_t;

  localparam obs_t IDLE_OBS = '{dout: 1'b1, valid: 1'b0, busy: 1'b0, done: 1'b0, fidx: 8'd0};

  obs_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   valid_cnt, busy_cnt, done_cnt;
  int   nbits, det_hits, first_hit;
  logic [7:0] det_win;
  vec_t vecs[7];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic obs_t cur_obs();
    return '{dout: dout_o, valid: dout_valid_o, busy: busy_o, done: done_o, fidx: frame_idx_o};
  endfunction

  // Reference stream for one transaction: W bits per frame, gap idles between frames, then done.
  task automatic push_frames(input logic [7:0] p, input int r, input int g);
    for (int f = 0; f <= r; f++) begin
      for (int b = 7; b >= 0; b--)
        sb.push_back('{dout: p[b], valid: 1'b1, busy: 1'b1, done: 1'b0, fidx: 8'(f)});
      if (f < r)
        for (int k = 0; k < g; k++)
          sb.push_back('{dout: 1'b1, valid: 1'b0, busy: 1'b1, done: 1'b0, fidx: 8'(f)});
    end
    sb.push_back('{dout: 1'b1, valid: 1'b0, busy: 1'b0, done: 1'b1, fidx: 8'd0});
  endtask

  task automatic tick();
    obs_t a, e;
    @(negedge clk);
    a = cur_obs();
    if (a.valid) begin
      valid_cnt++;
      nbits++;
      det_win = {det_win[6:0], a.dout};
      if (nbits >= 8 && det_win == PAT_0101) begin
        det_hits++;
        if (first_hit == 0) first_hit = nbits;
      end
    end
    if (a.busy) busy_cnt++;
    if (a.done) done_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(a == e, "cycle", int'(a), int'(e));
    end
  endtask

  task automatic start_tx(input logic [7:0] p, input int r, input int g, input bit ab, input bit sync);
    if (sync) tick();
    pattern_i = p;
    rpt_i     = 8'(r);
    gap_i     = 4'(g);
    start_i   = 1'b1;
    abort_i   = ab;
    valid_cnt = 0; busy_cnt = 0; done_cnt = 0;
    nbits = 0; det_hits = 0; first_hit = 0; det_win = '0;
    push_frames(p, r, g);
  endtask

  // Busy-time input noise: start may toggle until the done cycle is on the line.
  task automatic drain();
    for (int i = 0; i < 5000 && sb.size() > 0; i++) begin
      tick();
      abort_i   = 1'b0;
      start_i   = (sb.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      pattern_i = 8'($urandom);
      rpt_i     = 8'($urandom);
      gap_i     = 4'($urandom);
    end
    chk(sb.size() == 0, "drain_bound", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_vec(input vec_t v);
    start_tx(v.pat, v.rpt, v.gap, v.abort_too, 1'b1);
    drain();
    sb.push_back(IDLE_OBS);
    tick();
    chk(valid_cnt == v.exp_valid, "valid_bits", valid_cnt, v.exp_valid);
    chk(busy_cnt == v.exp_busy, "busy_cycles", busy_cnt, v.exp_busy);
    chk(done_cnt == 1, "done_pulses", done_cnt, 1);
    $display("tx pat=%02h rpt=%0d gap=%0d abort_w_start=%0d valid=%0d busy=%0d done=%0d",
             v.pat, v.rpt, v.gap, v.abort_too, valid_cnt, busy_cnt, done_cnt);
  endtask

  initial begin
    vecs[0] = '{8'h55, 0,   0,  1'b0, 8,    8};
    vecs[1] = '{8'hA5, 2,   0,  1'b0, 24,   24};
    vecs[2] = '{8'hF0, 1,   3,  1'b0, 16,   19};
    vecs[3] = '{8'h3C, 0,   0,  1'b1, 8,    8};
    vecs[4] = '{8'h81, 3,   1,  1'b0, 32,   35};
    vecs[5] = '{8'hC3, 1,   15, 1'b0, 16,   31};
    vecs[6] = '{8'hFF, 255, 0,  1'b0, 2048, 2048};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    pattern_i = '0; rpt_i = '0; gap_i = '0;
    #12;
    chk(cur_obs() == IDLE_OBS, "reset_state", int'(cur_obs()), int'(IDLE_OBS));
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back: second start lands in the done cycle of the first.
    start_tx(8'h55, 0, 0, 1'b0, 1'b1);
    drain();
    start_tx(8'h96, 0, 0, 1'b0, 1'b0);
    drain();
    sb.push_back(IDLE_OBS);
    tick();
    chk(done_cnt == 1, "b2b_done", done_cnt, 1);
    $display("tx back-to-back 55 then 96 done=%0d", done_cnt);

    // Abort while bit 4 is on the line.
    start_tx(8'h96, 2, 1, 1'b0, 1'b1);
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    abort_i = 1'b1;
    sb.delete();
    repeat (3) sb.push_back(IDLE_OBS);
    tick();
    abort_i = 1'b0;
    tick();
    tick();
    chk(done_cnt == 0, "abort_no_done", done_cnt, 0);
    chk(valid_cnt == 4, "abort_bits", valid_cnt, 4);
    $display("tx abort at bit 4 valid=%0d done=%0d", valid_cnt, done_cnt);

    // Asynchronous reset in the first gap cycle.
    start_tx(8'hF0, 1, 3, 1'b0, 1'b1);
    tick();
    start_i = 1'b0;
    repeat (8) tick();
    sb.delete();
    #2 rst = 1'b1;
    #1 chk(cur_obs() == IDLE_OBS, "async_reset", int'(cur_obs()), int'(IDLE_OBS));
    @(negedge clk) rst = 1'b0;
    sb.push_back(IDLE_OBS);
    sb.push_back(IDLE_OBS);
    tick();
    tick();
    chk(done_cnt == 0, "reset_no_done", done_cnt, 0);
    $display("tx reset mid-gap done=%0d", done_cnt);

    // Loopback into an overlapping 0101_0101 detector: hits on bits 8,10,12,14,16.
    start_tx(PAT_0101, 1, 0, 1'b0, 1'b1);
    drain();
    sb.push_back(IDLE_OBS);
    tick();
    chk(det_hits == 5, "det_hits", det_hits, 5);
    chk(first_hit == 8, "det_first", first_hit, 8);
    $display("tx loopback pat=55 rpt=1 hits=%0d first=%0d", det_hits, first_hit);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
